// File: rtl/cmp_sort_pkg.sv
// Shared types and defaults for the comparator-based block sorter.
// Imported by the sequencer and its magnitude comparator core.
package cmp_sort_pkg;

    localparam int W_DEF = 4;
    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/cmp_mag_core.sv
// Combinational W-bit magnitude comparator; exactly one output is high.
module cmp_mag_core
    import cmp_sort_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         a_grt_b,
    output logic         a_less_b,
    output logic         a_eq_b
);

    always_comb begin
        a_grt_b  = (a > b);
        a_less_b = (a < b);
        a_eq_b   = (a == b);
    end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Loads N words, bubble-sorts them in place with one shared comparator,
// then streams the sorted block out with a last marker.
module cmp_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int W      = W_DEF,
    parameter bit ASCEND = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int IW = $clog2(N);
    typedef logic [IW-1:0] idx_t;
    localparam idx_t LAST = idx_t'(N - 1);
    localparam idx_t LAST_PASS = idx_t'(N - 2);

    state_e       state_q, state_d;
    idx_t         wr_idx_q, wr_idx_d;
    idx_t         rd_idx_q, rd_idx_d;
    idx_t         i_q, i_d;
    idx_t         pass_q, pass_d;
    logic         swapped_q, swapped_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q, out_last_d;
    logic         busy_q, busy_d;
    logic [W-1:0] mem_q [N];
    logic [W-1:0] mem_d [N];

    idx_t         i_nx;
    logic [W-1:0] cmp_a, cmp_b;
    logic         a_grt_b, a_less_b, a_eq_b;
    logic         swap, swapped_now;

    assign i_nx  = i_q + 1'b1;
    assign cmp_a = mem_q[i_q];
    assign cmp_b = mem_q[i_nx];

    cmp_mag_core #(.W(W)) u_core (
        .a        (cmp_a),
        .b        (cmp_b),
        .a_grt_b  (a_grt_b),
        .a_less_b (a_less_b),
        .a_eq_b   (a_eq_b)
    );

    // Equal words never swap, keeping the sort stable.
    assign swap        = !a_eq_b && (ASCEND ? a_grt_b : a_less_b);
    assign swapped_now = swapped_q | swap;

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        i_d       = i_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        mem_d     = mem_q;
        unique case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_idx_q] = in_data;
                    wr_idx_d        = wr_idx_q + 1'b1;
                    if (wr_idx_q == LAST) begin
                        state_d   = ST_SORT;
                        wr_idx_d  = '0;
                        i_d       = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                    end
                end
            end
            ST_SORT: begin
                if (swap) begin
                    mem_d[i_q]  = cmp_b;
                    mem_d[i_nx] = cmp_a;
                end
                if (i_q == LAST_PASS - pass_q) begin
                    if (!swapped_now || pass_q == LAST_PASS) begin
                        state_d  = ST_DRAIN;
                        rd_idx_d = '0;
                    end else begin
                        i_d       = '0;
                        pass_d    = pass_q + 1'b1;
                        swapped_d = 1'b0;
                    end
                end else begin
                    i_d       = i_nx;
                    swapped_d = swapped_now;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST) begin
                        state_d  = ST_LOAD;
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
        // Abort drops the block but leaves storage untouched.
        if (abort) begin
            state_d   = ST_LOAD;
            wr_idx_d  = '0;
            rd_idx_d  = '0;
            i_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
            mem_d     = mem_q;
        end
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_DRAIN);
        out_last_d  = (state_d == ST_DRAIN) && (rd_idx_d == LAST);
        busy_d      = (state_d == ST_SORT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            i_q         <= '0;
            pass_q      <= '0;
            swapped_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < N; k++) mem_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            i_q         <= i_d;
            pass_q      <= pass_d;
            swapped_q   <= swapped_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            mem_q       <= mem_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign out_data  = mem_q[rd_idx_q];

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Scoreboard bench for cmp_sort_ctrl: ascending and descending instances,
// directed blocks, backpressure, abort/reset recovery.
module tb_cmp_sort_ctrl;

    typedef logic [3:0] blk_t [8];

    logic       clk;
    logic       rst;
    logic       abort;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [3:0] in_data, out_data;
    logic       b_abort;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic       b_out_last, b_busy;
    logic [3:0] b_in_data, b_out_data;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    int b_busy_cnt = 0;
    logic [4:0] exp_q [$];
    logic [4:0] b_exp_q [$];
    logic       stalled = 1'b0;
    logic [3:0] held = '0;

    cmp_sort_ctrl #(.N(8), .W(4), .ASCEND(1'b1)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    cmp_sort_ctrl #(.N(8), .W(4), .ASCEND(1'b0)) dut_desc (
        .clk(clk), .rst(rst), .abort(b_abort),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitors: pop expected word on every transfer, check hold while stalled.
    always @(negedge clk) begin
        if (out_valid) begin
            if (stalled) chk("stall_hold", out_data, held);
            stalled = !out_ready;
            held    = out_data;
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[3:0]);
                    chk("out_last", out_last, e[4]);
                end
            end
        end else begin
            stalled = 1'b0;
        end
        if (busy) busy_cnt++;
    end

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (b_exp_q.size() == 0) begin
                chk("desc_unexpected_out", 1, 0);
            end else begin
                logic [4:0] e;
                e = b_exp_q.pop_front();
                chk("desc_out_data", b_out_data, e[3:0]);
                chk("desc_out_last", b_out_last, e[4]);
            end
        end
        if (b_busy) b_busy_cnt++;
    end

    task automatic push_exp(input bit sel, input blk_t v);
        for (int k = 0; k < 8; k++) begin
            if (sel) b_exp_q.push_back({k == 7, v[k]});
            else     exp_q.push_back({k == 7, v[k]});
        end
    endtask

    task automatic load_block(input bit sel, input blk_t v, input int n, input bit hold);
        for (int k = 0; k < n; k++) begin
            if (sel) begin b_in_valid = 1'b1; b_in_data = v[k]; end
            else     begin in_valid = 1'b1;   in_data = v[k];   end
            @(posedge clk); #1;
        end
        if (!hold) begin
            in_valid   = 1'b0;
            b_in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input bit sel, input bit rnd);
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk); #1;
            if ((sel ? b_exp_q.size() : exp_q.size()) == 0) done = 1'b1;
            else if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        chk("drain_timeout", done, 1);
        if (sel) chk("desc_in_ready_after", b_in_ready, 1);
        else begin
            chk("in_ready_after", in_ready, 1);
            chk("out_valid_after", out_valid, 0);
        end
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; b_abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);

        // Mixed block with duplicates.
        push_exp(0, '{4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 4'h7, 4'h8, 4'hF});
        load_block(0, '{4'h8, 4'h3, 4'hF, 4'h0, 4'h3, 4'h1, 4'h7, 4'h2}, 8, 0);
        wait_drain(0, 0);

        // Already sorted: one pass only.
        busy_cnt = 0;
        push_exp(0, '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7});
        load_block(0, '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7}, 8, 0);
        wait_drain(0, 0);
        chk("sorted_busy", busy_cnt, 7);

        // Reverse block: worst case ascending, best case descending.
        busy_cnt = 0;
        push_exp(0, '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF});
        load_block(0, '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8}, 8, 0);
        wait_drain(0, 0);
        chk("reverse_busy", busy_cnt, 28);
        b_busy_cnt = 0;
        push_exp(1, '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8});
        load_block(1, '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8}, 8, 0);
        wait_drain(1, 0);
        chk("desc_busy", b_busy_cnt, 7);

        // Random backpressure during drain.
        out_ready = 1'b0;
        push_exp(0, '{4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 4'h7, 4'h8, 4'hF});
        load_block(0, '{4'h8, 4'h3, 4'hF, 4'h0, 4'h3, 4'h1, 4'h7, 4'h2}, 8, 0);
        wait_drain(0, 1);
        repeat (3) @(posedge clk);
        #1 chk("no_extra_out", out_valid, 0);

        // Abort in the middle of a long sort.
        load_block(0, '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8}, 8, 0);
        repeat (5) @(posedge clk);
        #1 chk("pre_abort_busy", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        push_exp(0, '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7});
        load_block(0, '{4'h7, 4'h0, 4'h5, 4'h2, 4'h6, 4'h1, 4'h4, 4'h3}, 8, 0);
        wait_drain(0, 0);

        // Reset after a partial load.
        load_block(0, '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h0, 4'h0, 4'h0}, 5, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_out_data", out_data, 0);
        push_exp(0, '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h9, 4'hC, 4'hE});
        load_block(0, '{4'h9, 4'h9, 4'h1, 4'hC, 4'h4, 4'hE, 4'h0, 4'h2}, 8, 0);
        wait_drain(0, 0);

        // in_valid held high through sort and drain must capture nothing.
        push_exp(0, '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7});
        load_block(0, '{4'h3, 4'h1, 4'h2, 4'h0, 4'h7, 4'h6, 4'h5, 4'h4}, 8, 1);
        in_data = 4'hA;
        wait_drain(0, 0);
        in_valid = 1'b0;

        // All-equal block.
        busy_cnt = 0;
        push_exp(0, '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5});
        load_block(0, '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5}, 8, 0);
        wait_drain(0, 0);
        chk("equal_busy", busy_cnt, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
